// File: rtl/hazard_sequencer_if.sv
// Hazard sequencer control bundle: hazard sources in, pipeline enables out.
// Optional HAZARD_PERF_CNT_EN adds the stall/flush performance counters.
interface hazard_sequencer_if;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [4:0]  ex_rd;
    logic        ex_mem_read;
    logic        ex_branch_taken;
    logic        id_halt;
    logic        dmem_busy;
    logic        pc_write;
    logic        ifid_write;
    logic        idex_write;
    logic        exmem_write;
    logic        memwb_write;
    logic        ifid_flush;
    logic        idex_flush;
    logic        halted;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles;
    logic [31:0] flush_count;

    modport master (
        output id_rs1, id_rs2, ex_rd, ex_mem_read,
        output ex_branch_taken, id_halt, dmem_busy,
        input  pc_write, ifid_write, idex_write,
        input  exmem_write, memwb_write,
        input  ifid_flush, idex_flush, halted,
        input  stall_cycles, flush_count
    );

    modport slave (
        input  id_rs1, id_rs2, ex_rd, ex_mem_read,
        input  ex_branch_taken, id_halt, dmem_busy,
        output pc_write, ifid_write, idex_write,
        output exmem_write, memwb_write,
        output ifid_flush, idex_flush, halted,
        output stall_cycles, flush_count
    );
`else
    modport master (
        output id_rs1, id_rs2, ex_rd, ex_mem_read,
        output ex_branch_taken, id_halt, dmem_busy,
        input  pc_write, ifid_write, idex_write,
        input  exmem_write, memwb_write,
        input  ifid_flush, idex_flush, halted
    );

    modport slave (
        input  id_rs1, id_rs2, ex_rd, ex_mem_read,
        input  ex_branch_taken, id_halt, dmem_busy,
        output pc_write, ifid_write, idex_write,
        output exmem_write, memwb_write,
        output ifid_flush, idex_flush, halted
    );
`endif
endinterface

// File: rtl/hazard_sequencer.sv
// Pipeline hazard/freeze/halt sequencer for a 5-stage core.
// Define HAZARD_PERF_CNT_EN to add stall_cycles/flush_count counters.
module hazard_sequencer #(
    parameter int unsigned DRAIN_CYCLES = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    hazard_sequencer_if.slave   hz
);

    typedef enum logic [1:0] {
        RUN,
        MEM_WAIT,
        DRAIN,
        HALTED
    } state_e;

    localparam logic [1:0] DRAIN_INIT = 2'(DRAIN_CYCLES);

    state_e     state_q, state_d;
    logic [1:0] drain_cnt_q, drain_cnt_d;
    logic       load_use;
    logic       branch_ev;
    logic       pc_w, ifid_w, idex_w, exmem_w, memwb_w;
    logic       ifid_fl, idex_fl, halt_o;

    always_comb begin
        load_use = hz.ex_mem_read && (hz.ex_rd != 5'd0) &&
                   ((hz.ex_rd == hz.id_rs1) || (hz.ex_rd == hz.id_rs2));
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        branch_ev   = 1'b0;
        pc_w        = 1'b1;
        ifid_w      = 1'b1;
        idex_w      = 1'b1;
        exmem_w     = 1'b1;
        memwb_w     = 1'b1;
        ifid_fl     = 1'b0;
        idex_fl     = 1'b0;
        halt_o      = 1'b0;
        if (!reset_n) begin
            {pc_w, ifid_w, idex_w, exmem_w, memwb_w} = 5'b0;
            ifid_fl = 1'b1;
            idex_fl = 1'b1;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (hz.dmem_busy) begin
                        {pc_w, ifid_w, idex_w, exmem_w, memwb_w} = 5'b0;
                        state_d = MEM_WAIT;
                    end else if (hz.ex_branch_taken) begin
                        ifid_fl   = 1'b1;
                        idex_fl   = 1'b1;
                        branch_ev = 1'b1;
                    end else if (load_use) begin
                        pc_w    = 1'b0;
                        ifid_w  = 1'b0;
                        idex_fl = 1'b1;
                    end else if (hz.id_halt) begin
                        pc_w        = 1'b0;
                        ifid_w      = 1'b0;
                        idex_fl     = 1'b1;
                        drain_cnt_d = DRAIN_INIT;
                        state_d     = DRAIN;
                    end
                end
                MEM_WAIT: begin
                    // Freeze holds through the cycle busy drops.
                    {pc_w, ifid_w, idex_w, exmem_w, memwb_w} = 5'b0;
                    if (!hz.dmem_busy) state_d = RUN;
                end
                DRAIN: begin
                    pc_w    = 1'b0;
                    ifid_w  = 1'b0;
                    idex_fl = 1'b1;
                    if (hz.dmem_busy) begin
                        {pc_w, ifid_w, idex_w, exmem_w, memwb_w} = 5'b0;
                    end else if (drain_cnt_q <= 2'd1) begin
                        drain_cnt_d = 2'd0;
                        state_d     = HALTED;
                    end else begin
                        drain_cnt_d = drain_cnt_q - 2'd1;
                    end
                end
                HALTED: begin
                    {pc_w, ifid_w, idex_w, exmem_w, memwb_w} = 5'b0;
                    halt_o = 1'b1;
                end
                default: state_d = RUN;
            endcase
        end
    end

    assign hz.pc_write    = pc_w;
    assign hz.ifid_write  = ifid_w;
    assign hz.idex_write  = idex_w;
    assign hz.exmem_write = exmem_w;
    assign hz.memwb_write = memwb_w;
    assign hz.ifid_flush  = ifid_fl;
    assign hz.idex_flush  = idex_fl;
    assign hz.halted      = halt_o;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] flush_count_q, flush_count_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;
        if (!pc_w && (state_q != HALTED) && (stall_cycles_q != '1))
            stall_cycles_d = stall_cycles_q + 32'd1;
        if (branch_ev && (flush_count_q != '1))
            flush_count_d = flush_count_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign hz.stall_cycles = stall_cycles_q;
    assign hz.flush_count  = flush_count_q;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= RUN;
            drain_cnt_q <= 2'd0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed self-checking bench for hazard_sequencer (DRAIN_CYCLES = 2).
// Perf-counter checks compile in only with HAZARD_PERF_CNT_EN.
module tb_hazard_sequencer;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    hazard_sequencer_if hz ();

    hazard_sequencer #(.DRAIN_CYCLES(2)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .hz      (hz.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {pc,ifid,idex,exmem,memwb write, ifid_flush, idex_flush, halted}
    logic [7:0] obs;
    assign obs = {hz.pc_write, hz.ifid_write, hz.idex_write,
                  hz.exmem_write, hz.memwb_write,
                  hz.ifid_flush, hz.idex_flush, hz.halted};

    localparam logic [7:0] O_RUN   = 8'hF8;
    localparam logic [7:0] O_FRZ   = 8'h00;
    localparam logic [7:0] O_BR    = 8'hFE;
    localparam logic [7:0] O_STALL = 8'h3A;
    localparam logic [7:0] O_HALT  = 8'h01;
    localparam logic [7:0] O_RST   = 8'h06;
    localparam logic [7:0] M_NOFL  = 8'hF9;

    task automatic chk(input string tag, input logic [7:0] o,
                       input logic [7:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, o, e);
        end
    endtask

`ifdef HAZARD_PERF_CNT_EN
    task automatic chk32(input string tag, input logic [31:0] o,
                         input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, o, e);
        end
    endtask
`endif

    task automatic idle();
        hz.id_rs1 = 5'd0;
        hz.id_rs2 = 5'd0;
        hz.ex_rd = 5'd0;
        hz.ex_mem_read = 1'b0;
        hz.ex_branch_taken = 1'b0;
        hz.id_halt = 1'b0;
        hz.dmem_busy = 1'b0;
    endtask

    task automatic step();
        @(negedge clk);
        idle();
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset_n = 1'b0;
        idle();
        step(); #1 chk("reset_out", obs, O_RST);
        step(); reset_n = 1'b1; #1 chk("run_default", obs, O_RUN);

        step(); hz.ex_mem_read = 1'b1; hz.ex_rd = 5'd5; hz.id_rs2 = 5'd5;
        #1 chk("lu_rs2", obs, O_STALL);
        step(); #1 chk("lu_one_cycle", obs, O_RUN);
        step(); hz.ex_mem_read = 1'b1; hz.ex_rd = 5'd0;
        #1 chk("lu_rd0", obs, O_RUN);
        step(); hz.ex_mem_read = 1'b1; hz.ex_rd = 5'd7; hz.id_rs1 = 5'd7;
        #1 chk("lu_rs1", obs, O_STALL);
        step(); hz.ex_rd = 5'd7; hz.id_rs1 = 5'd7;
        #1 chk("no_load", obs, O_RUN);
`ifdef HAZARD_PERF_CNT_EN
        chk32("stall_cnt", hz.stall_cycles, 32'd2);
        chk32("flush_cnt0", hz.flush_count, 32'd0);
`endif

        step(); hz.ex_branch_taken = 1'b1;
        #1 chk("branch", obs, O_BR);
        step(); #1 chk("after_branch", obs, O_RUN);
`ifdef HAZARD_PERF_CNT_EN
        chk32("flush_cnt1", hz.flush_count, 32'd1);
`endif
        step(); hz.ex_branch_taken = 1'b1;
        hz.ex_mem_read = 1'b1; hz.ex_rd = 5'd3; hz.id_rs1 = 5'd3;
        #1 chk("branch_over_lu", obs, O_BR);

        step(); hz.dmem_busy = 1'b1; hz.ex_branch_taken = 1'b1;
        #1 chk("mw_c1", obs, O_FRZ);
        step(); hz.dmem_busy = 1'b1; hz.ex_branch_taken = 1'b1;
        #1 chk("mw_c2", obs, O_FRZ);
        step(); hz.dmem_busy = 1'b1; hz.ex_branch_taken = 1'b1;
        #1 chk("mw_c3", obs, O_FRZ);
        step(); hz.ex_branch_taken = 1'b1;
        #1 chk("mw_c4_fall", obs, O_FRZ);
        step(); hz.ex_branch_taken = 1'b1;
        #1 chk("mw_c5_flush", obs, O_BR);
        step(); #1 chk("mw_done", obs, O_RUN);

        step(); hz.dmem_busy = 1'b1; hz.ex_branch_taken = 1'b1;
        hz.ex_mem_read = 1'b1; hz.ex_rd = 5'd9; hz.id_rs2 = 5'd9;
        hz.id_halt = 1'b1;
        #1 chk("prio_freeze", obs, O_FRZ);
        step(); #1 chk("prio_memwait", obs, O_FRZ);
        step(); #1 chk("prio_back_run", obs, O_RUN);

        step(); hz.id_halt = 1'b1;
        #1 chk("halt_detect", obs, O_STALL);
        step(); hz.ex_branch_taken = 1'b1; hz.id_halt = 1'b1;
        #1 chk("drain1_ignores", obs, O_STALL);
        step(); #1 chk("drain2", obs, O_STALL);
        step(); hz.ex_branch_taken = 1'b1;
        #1 chk("halted", obs, O_HALT);
        step(); hz.dmem_busy = 1'b1;
        #1 chk("halted_stays", obs, O_HALT);

        step(); reset_n = 1'b0;
        #1 chk("reset_halted", obs, O_RST);
        step(); reset_n = 1'b1; #1 chk("post_reset_run", obs, O_RUN);

        step(); hz.id_halt = 1'b1;
        #1 chk("halt2_detect", obs, O_STALL);
        step(); hz.dmem_busy = 1'b1;
        #1 chk("drain_busy", obs & M_NOFL, O_FRZ);
        step(); #1 chk("drain_x1", obs, O_STALL);
        step(); #1 chk("drain_x2", obs, O_STALL);
        step(); #1 chk("halted_late", obs, O_HALT);

        step(); reset_n = 1'b0;
        step(); reset_n = 1'b1;
        step(); hz.id_halt = 1'b1;
        #1 chk("halt3_detect", obs, O_STALL);
        step(); #1 chk("drain_pre_rst", obs, O_STALL);
        step(); reset_n = 1'b0;
        #1 chk("reset_in_drain", obs, O_RST);
        step(); reset_n = 1'b1; #1 chk("rel_run", obs, O_RUN);
        step(); #1 chk("no_residual", obs, O_RUN);
`ifdef HAZARD_PERF_CNT_EN
        chk32("stall_cleared", hz.stall_cycles, 32'd0);
        chk32("flush_cleared", hz.flush_count, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
